// File: rtl/vertex_transform_seq.sv
// vertex_transform_seq
// Streams a vertex list from a synchronous-read vertex RAM through an external
// combinational 4x4 homogeneous transform stage and hands each transformed
// point downstream over a valid/ready handshake.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   start             begin a pass (sampled only in IDLE)
//   num_vertices      vertex count for the pass, latched at start
//   busy, done        pass in progress / one-cycle end-of-pass pulse
//   mem_addr          registered vertex RAM read address
//   mem_rdata         {z,y,x} returned one cycle after mem_addr
//   mul_p             homogeneous point (x,y,z,1.0) to the transform stage
//   mul_Pp            transformed point from the transform stage
//   out_point         registered {z',y',x'} (w' discarded)
//   out_index         vertex index of out_point
//   out_last          out_point is the final vertex of the pass
//   out_valid         out_point/out_index/out_last valid
//   out_ready         downstream accepts; transfer on out_valid & out_ready
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// FETCH | mem_addr stable, RAM registering it
// LOAD  | mem_rdata valid, build p register
// XFORM | p presented to transform stage, result captured at cycle end
// OUT   | out_valid held until handshake
// DONE  | one-cycle done pulse, busy low
module vertex_transform_seq #(
  parameter int WII    = 9,
  parameter int WIF    = 16,
  parameter int ADDR_W = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [ADDR_W:0]                 num_vertices,
  output logic                            busy,
  output logic                            done,
  output logic [ADDR_W-1:0]               mem_addr,
  input  logic [2:0][WII+WIF-1:0]         mem_rdata,
  output logic [3:0][WII+WIF-1:0]         mul_p,
  input  logic [3:0][WII+WIF-1:0]         mul_Pp,
  output logic [2:0][WII+WIF-1:0]         out_point,
  output logic [ADDR_W-1:0]               out_index,
  output logic                            out_last,
  output logic                            out_valid,
  input  logic                            out_ready
);

  localparam logic [WII+WIF-1:0] FIX_ONE = {{(WII-1){1'b0}}, 1'b1, {WIF{1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    XFORM = 3'd3,
    OUT   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                     state;
  logic [ADDR_W:0]            nv;
  logic [ADDR_W-1:0]          idx;
  logic [3:0][WII+WIF-1:0]    p_reg;
  logic [ADDR_W:0]            nv_m1;
  logic                       is_last;

  // Compare at ADDR_W+1 bits so a full list of 2^ADDR_W vertices ends on
  // idx = 2^ADDR_W-1 without idx ever wrapping.
  assign nv_m1   = nv - {{ADDR_W{1'b0}}, 1'b1};
  assign is_last = ({1'b0, idx} == nv_m1);
  assign mul_p   = p_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      nv        <= '0;
      idx       <= '0;
      p_reg     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      out_point <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            nv       <= num_vertices;
            idx      <= '0;
            mem_addr <= '0;
            if (num_vertices == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
              busy  <= 1'b1;
            end
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          p_reg <= {FIX_ONE, mem_rdata[2], mem_rdata[1], mem_rdata[0]};
          state <= XFORM;
        end
        XFORM: begin
          out_point <= mul_Pp[2:0];
          out_index <= idx;
          out_last  <= is_last;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx      <= idx + ADDR_W'(1);
              mem_addr <= idx + ADDR_W'(1);
              state    <= FETCH;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vertex_transform_seq.sv
// tb_vertex_transform_seq
// Bench for vertex_transform_seq: models the vertex RAM and the combinational
// transform stage, and scores every output handshake against a queue of
// expected points filled when each pass is set up.
module tb_vertex_transform_seq;

  localparam int WII = 9;
  localparam int WIF = 16;
  localparam int AW  = 8;
  localparam int W   = WII + WIF;
  localparam logic [W-1:0] ONE = 25'h0010000;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic [AW:0]           num_vertices = '0;
  logic                  busy, done;
  logic [AW-1:0]         mem_addr;
  logic [2:0][W-1:0]     mem_rdata = '0;
  logic [3:0][W-1:0]     mul_p, mul_Pp;
  logic [2:0][W-1:0]     out_point;
  logic [AW-1:0]         out_index;
  logic                  out_last, out_valid;
  logic                  out_ready = 1'b1;

  logic [2:0][W-1:0]     ram [0:255];
  logic [3:0][3:0][W-1:0] h_mat;

  typedef struct packed {
    logic [AW-1:0]     idx;
    logic              last;
    logic [2:0][W-1:0] pt;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int passed = 0;
  int done_cnt = 0;
  int hs_cnt = 0;

  vertex_transform_seq #(.WII(WII), .WIF(WIF), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_vertices(num_vertices),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mul_p(mul_p), .mul_Pp(mul_Pp), .out_point(out_point),
    .out_index(out_index), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= ram[mem_addr];

  function automatic logic [3:0][W-1:0] xform(input logic [3:0][3:0][W-1:0] h,
                                              input logic [3:0][W-1:0] p);
    logic [3:0][W-1:0] r;
    longint acc;
    for (int i = 0; i < 4; i++) begin
      acc = 0;
      for (int j = 0; j < 4; j++)
        acc += longint'($signed(h[i][j])) * longint'($signed(p[j]));
      r[i] = W'(acc >>> WIF);
    end
    return r;
  endfunction

  assign mul_Pp = xform(h_mat, mul_p);

  // Scoreboard: every handshake pops one expected entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        hs_cnt++;
        total++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected: got idx=%0d last=%0b pt=%h, required no output",
                   out_index, out_last, out_point);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if ({out_index, out_last, out_point} !== e)
            $display("FAIL sb_output: got idx=%0d last=%0b pt=%h, required idx=%0d last=%0b pt=%h",
                     out_index, out_last, out_point, e.idx, e.last, e.pt);
          else passed++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input logic [AW:0] nv);
    start = 1'b1;
    num_vertices = nv;
    tick();
    start = 1'b0;
  endtask

  task automatic set_identity();
    h_mat = '0;
    for (int i = 0; i < 4; i++) h_mat[i][i] = ONE;
  endtask

  task automatic load_expected(input int n);
    exp_t e;
    logic [3:0][W-1:0] r;
    for (int i = 0; i < n; i++) begin
      r      = xform(h_mat, {ONE, ram[i][2], ram[i][1], ram[i][0]});
      e.idx  = AW'(i);
      e.last = (i == n - 1);
      e.pt   = r[2:0];
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    total++;
    if ({busy, done, out_valid, out_last} !== 4'b0)
      $display("FAIL reset_flags: got %b, required 0000", {busy, done, out_valid, out_last});
    else passed++;
    total++;
    if ({mem_addr, out_index, out_point, mul_p} !== '0)
      $display("FAIL reset_data: got addr=%h idx=%h pt=%h p=%h, required all 0",
               mem_addr, out_index, out_point, mul_p);
    else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_identity();
    int d0;
    set_identity();
    ram[0] = {25'h1FD0000, 25'h0020000, 25'h0010000};
    load_expected(1);
    d0 = done_cnt;
    issue_start(9'd1);
    total++;
    if ({busy, mem_addr} !== {1'b1, 8'd0})
      $display("FAIL id_cycle1: got busy=%b addr=%0d, required busy=1 addr=0", busy, mem_addr);
    else passed++;
    tick(); tick();
    total++;
    if (mul_p !== {ONE, 25'h1FD0000, 25'h0020000, 25'h0010000})
      $display("FAIL id_mul_p: got %h, required %h", mul_p,
               {ONE, 25'h1FD0000, 25'h0020000, 25'h0010000});
    else passed++;
    tick();
    total++;
    if ({out_valid, out_index, out_last, out_point} !==
        {1'b1, 8'd0, 1'b1, 25'h1FD0000, 25'h0020000, 25'h0010000})
      $display("FAIL id_cycle4: got v=%b idx=%0d last=%b pt=%h, required v=1 idx=0 last=1 pt=1fd0000_0020000_0010000",
               out_valid, out_index, out_last, out_point);
    else passed++;
    tick();
    total++;
    if ({done, busy, out_valid} !== 3'b100)
      $display("FAIL id_cycle5: got done=%b busy=%b v=%b, required 1 0 0", done, busy, out_valid);
    else passed++;
    tick();
    total++;
    if ({done, busy, done_cnt - d0, sb.size()} !== {1'b0, 1'b0, 32'd1, 32'd0})
      $display("FAIL id_after: got done=%b busy=%b dones=%0d left=%0d, required 0 0 1 0",
               done, busy, done_cnt - d0, sb.size());
    else passed++;
  endtask

  task automatic load_trans_list();
    h_mat = '0;
    for (int i = 0; i < 4; i++) h_mat[i][i] = ONE;
    h_mat[0][3] = 25'h0008000;
    for (int i = 0; i < 3; i++)
      ram[i] = {W'(i * 16'h4000), W'(i * 16'h3000), W'(i) << WIF};
  endtask

  task automatic push_trans_expected();
    logic [W-1:0] xs [3];
    exp_t e;
    xs[0] = 25'h0008000; xs[1] = 25'h0018000; xs[2] = 25'h0028000;
    for (int i = 0; i < 3; i++) begin
      e.idx  = AW'(i);
      e.last = (i == 2);
      e.pt   = {W'(i * 16'h4000), W'(i * 16'h3000), xs[i]};
      sb.push_back(e);
    end
  endtask

  task automatic test_translation();
    int vc[$];
    int dc, d0, h0, c;
    load_trans_list();
    push_trans_expected();
    d0 = done_cnt; h0 = hs_cnt; dc = -1;
    out_ready = 1'b1;
    issue_start(9'd3);
    c = 1;
    while (c < 40) begin
      if (out_valid) vc.push_back(c);
      if (done) begin dc = c; break; end
      tick();
      c++;
    end
    tick();
    total++;
    if (vc.size() != 3 || vc[0] != 4 || vc[1] != 8 || vc[2] != 12)
      $display("FAIL tr_valid_cycles: got %p, required '{4,8,12}", vc);
    else passed++;
    total++;
    if (dc != 13)
      $display("FAIL tr_done_cycle: got %0d, required 13", dc);
    else passed++;
    total++;
    if (done_cnt - d0 != 1 || hs_cnt - h0 != 3 || sb.size() != 0)
      $display("FAIL tr_counts: got dones=%0d outs=%0d left=%0d, required 1 3 0",
               done_cnt - d0, hs_cnt - h0, sb.size());
    else passed++;
  endtask

  task automatic test_stall();
    logic [2:0][W-1:0] cap;
    logic [AW-1:0] hold;
    int d0, h0, bad;
    bit ok;
    load_trans_list();
    push_trans_expected();
    d0 = done_cnt; h0 = hs_cnt; ok = 1'b0; bad = 0;
    out_ready = 1'b1;
    issue_start(9'd3);
    for (int c = 0; c < 30; c++) begin
      if (out_valid && out_index == 8'd1) begin ok = 1'b1; break; end
      tick();
    end
    out_ready = 1'b0;
    cap = out_point;
    hold = mem_addr;
    total++;
    if (!ok || hold !== 8'd1)
      $display("FAIL st_reach: got found=%0b addr=%0d, required found=1 addr=1", ok, hold);
    else passed++;
    for (int c = 0; c < 10; c++) begin
      tick();
      if ({out_valid, out_index, out_point, mem_addr} !== {1'b1, 8'd1, cap, hold}) bad++;
    end
    total++;
    if (bad != 0)
      $display("FAIL st_hold: got %0d unstable cycles, required 0", bad);
    else passed++;
    out_ready = 1'b1;
    wait_done(40, ok);
    tick();
    total++;
    if (!ok || done_cnt - d0 != 1 || hs_cnt - h0 != 3 || sb.size() != 0)
      $display("FAIL st_counts: got done_seen=%0b dones=%0d outs=%0d left=%0d, required 1 1 3 0",
               ok, done_cnt - d0, hs_cnt - h0, sb.size());
    else passed++;
  endtask

  task automatic test_zero();
    int d0, vseen;
    d0 = done_cnt; vseen = 0;
    issue_start(9'd0);
    total++;
    if ({done, busy, out_valid} !== 3'b100)
      $display("FAIL zero_cycle1: got done=%b busy=%b v=%b, required 1 0 0", done, busy, out_valid);
    else passed++;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (out_valid || busy) vseen++;
    end
    total++;
    if (vseen != 0 || done_cnt - d0 != 1)
      $display("FAIL zero_after: got activity=%0d dones=%0d, required 0 1", vseen, done_cnt - d0);
    else passed++;
  endtask

  task automatic test_restart();
    int d0, h0, act;
    bit ok;
    set_identity();
    for (int i = 0; i < 4; i++)
      ram[i] = {W'($urandom), W'($urandom), W'($urandom)};
    load_expected(4);
    d0 = done_cnt; h0 = hs_cnt; act = 0;
    out_ready = 1'b1;
    issue_start(9'd4);
    tick();
    issue_start(9'd7);
    repeat (5) tick();
    issue_start(9'd7);
    wait_done(40, ok);
    start = 1'b1;
    num_vertices = 9'd2;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (busy || out_valid || done) act++;
      tick();
    end
    total++;
    if (!ok || act != 0)
      $display("FAIL rs_ignored: got done_seen=%0b activity_after=%0d, required 1 0", ok, act);
    else passed++;
    total++;
    if (done_cnt - d0 != 1 || hs_cnt - h0 != 4 || sb.size() != 0)
      $display("FAIL rs_counts: got dones=%0d outs=%0d left=%0d, required 1 4 0",
               done_cnt - d0, hs_cnt - h0, sb.size());
    else passed++;
  endtask

  task automatic test_full_list();
    int d0, h0;
    bit ok;
    h_mat = '0;
    h_mat[0][0] = 25'h0020000;
    h_mat[1][1] = ONE;
    h_mat[1][3] = 25'h1FF0000;
    h_mat[2][2] = 25'h0008000;
    h_mat[2][0] = 25'h0004000;
    h_mat[3][3] = ONE;
    for (int i = 0; i < 256; i++)
      ram[i] = {W'($urandom), W'($urandom), W'($urandom)};
    load_expected(256);
    d0 = done_cnt; h0 = hs_cnt;
    out_ready = 1'b1;
    issue_start(9'd256);
    wait_done(1200, ok);
    tick();
    total++;
    if (!ok || done_cnt - d0 != 1 || hs_cnt - h0 != 256 || sb.size() != 0)
      $display("FAIL full_counts: got done_seen=%0b dones=%0d outs=%0d left=%0d, required 1 1 256 0",
               ok, done_cnt - d0, hs_cnt - h0, sb.size());
    else passed++;
  endtask

  task automatic test_reset_mid();
    int h0;
    bit ok;
    set_identity();
    for (int i = 0; i < 4; i++)
      ram[i] = {W'($urandom), W'($urandom), W'($urandom)};
    load_expected(4);
    out_ready = 1'b1;
    issue_start(9'd4);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid && out_index == 8'd2) begin ok = 1'b1; break; end
      tick();
    end
    out_ready = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    total++;
    if (!ok || {busy, done, out_valid, out_last, mem_addr, out_index, out_point, mul_p} !== '0)
      $display("FAIL rm_outputs: got found=%0b busy=%b done=%b v=%b last=%b addr=%h idx=%h pt=%h p=%h, required found=1 all 0",
               ok, busy, done, out_valid, out_last, mem_addr, out_index, out_point, mul_p);
    else passed++;
    reset = 1'b0;
    out_ready = 1'b1;
    sb.delete();
    tick();
    total++;
    if ({busy, out_valid} !== 2'b00)
      $display("FAIL rm_idle: got busy=%b v=%b, required 0 0", busy, out_valid);
    else passed++;
    for (int i = 0; i < 2; i++)
      ram[i] = {W'($urandom), W'($urandom), W'($urandom)};
    load_expected(2);
    h0 = hs_cnt;
    issue_start(9'd2);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin ok = 1'b1; break; end
      tick();
    end
    total++;
    if (!ok || out_index !== 8'd0)
      $display("FAIL rm_first_index: got found=%0b idx=%0d, required found=1 idx=0", ok, out_index);
    else passed++;
    wait_done(40, ok);
    tick();
    total++;
    if (!ok || hs_cnt - h0 != 2 || sb.size() != 0)
      $display("FAIL rm_counts: got done_seen=%0b outs=%0d left=%0d, required 1 2 0",
               ok, hs_cnt - h0, sb.size());
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    set_identity();
    test_reset();
    test_identity();
    test_translation();
    test_stall();
    test_zero();
    test_restart();
    test_full_list();
    test_reset_mid();
    repeat (2) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
